// File: rtl/snake_pkg.sv
// Shared snake-game types: coordinate widths, play-field limits, address type,
// the default target cell and the target-placement state encoding.
package snake_pkg;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned ADDR_W = X_W + Y_W;

    localparam int unsigned X_MIN = 1;
    localparam int unsigned X_MAX = 158;
    localparam int unsigned Y_MIN = 1;
    localparam int unsigned Y_MAX = 118;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t DEF_ADDR = {8'd55, 7'd13};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK_BLK,
        ST_CHECK_BODY,
        ST_COMMIT,
        ST_FALLBACK
    } state_t;

    // True when the cell lies strictly inside the wall ring.
    function automatic logic in_field(input addr_t a);
        return (a[ADDR_W-1:Y_W] >= X_W'(X_MIN)) && (a[ADDR_W-1:Y_W] <= X_W'(X_MAX)) &&
               (a[Y_W-1:0]      >= Y_W'(Y_MIN)) && (a[Y_W-1:0]      <= Y_W'(Y_MAX));
    endfunction

endpackage

// File: rtl/addr_hit_cmp.sv
// Parallel full-width equality of one candidate cell against a flattened list
// of cell addresses; shared with the collision logic.
module addr_hit_cmp
    import snake_pkg::*;
#(
    parameter int unsigned NUM = 4
) (
    input  logic [ADDR_W-1:0]     cand,
    input  logic [NUM*ADDR_W-1:0] addrs,
    output logic                  hit_c
);

    always_comb begin
        hit_c = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (addrs[k*ADDR_W +: ADDR_W] == cand) hit_c = 1'b1;
        end
    end

endmodule

// File: rtl/target_placement_ctrl.sv
// Places a new apple target: samples the LFSRs, rejects walls, obstacles and
// body cells, retries, and falls back. TARGET_SCAN_FALLBACK_EN enables a field sweep.
module target_placement_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned NUM_BLK   = 4,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned LEN_W     = $clog2(MAX_LEN),
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      Place_Req,
    input  logic [7:0]                Rand_X,
    input  logic [6:0]                Rand_Y,
    input  logic [NUM_BLK*ADDR_W-1:0] Block_Address,
    input  logic [LEN_W-1:0]          Body_Len,
    output logic [LEN_W-1:0]          Body_Rd_Addr,
    input  logic [ADDR_W-1:0]         Body_Rd_Data,
    output logic [ADDR_W-1:0]         Target_Address,
    output logic                      Place_Done,
    output logic                      Place_Fail,
    output logic                      Busy
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    state_t             state, state_next;
    addr_t              cand, cand_d;
    logic [TRY_W-1:0]   tries, tries_d;
    logic               scan_vld, scan_vld_d;
    logic [LEN_W-1:0]   rd_addr_d;
    addr_t              target_d;
    logic               done_d, fail_d;

    addr_t  samp;
    logic   samp_ok, blk_hit, body_hit, body_last, reject_c, tries_last;
    state_t reject_state;

    assign samp       = {Rand_X, Rand_Y};
    assign samp_ok    = in_field(samp);
    assign body_hit   = scan_vld && (Body_Rd_Data == cand);
    // Read data lags the index by one cycle, so the last segment is seen when the index equals the length.
    assign body_last  = scan_vld && (Body_Rd_Addr == Body_Len);
    assign tries_last = (tries == TRY_W'(MAX_TRIES - 1));

    assign reject_c = ((state == ST_SAMPLE)     && !samp_ok) ||
                      ((state == ST_CHECK_BLK)  && blk_hit)  ||
                      ((state == ST_CHECK_BODY) && body_hit);

    addr_hit_cmp #(.NUM(NUM_BLK)) u_blk_cmp (
        .cand  (cand),
        .addrs (Block_Address),
        .hit_c (blk_hit)
    );

`ifdef TARGET_SCAN_FALLBACK_EN
    localparam int unsigned SWEEP_CELLS = (X_MAX - X_MIN + 1) * (Y_MAX - Y_MIN + 1);
    localparam int unsigned SWEEP_W     = $clog2(SWEEP_CELLS + 1);

    logic               sweep_on, sweep_on_d;
    logic [SWEEP_W-1:0] sweep_cnt, sweep_cnt_d;
    logic               sweep_end;

    assign sweep_end = (sweep_cnt == SWEEP_W'(SWEEP_CELLS));

    // Next cell in raster order; out-of-field coordinates snap back into the field.
    function automatic addr_t step_cell(input addr_t a);
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           carry;
        x     = a[ADDR_W-1:Y_W];
        y     = a[Y_W-1:0];
        carry = (x >= X_W'(X_MAX)) || (x < X_W'(X_MIN));
        x     = carry ? X_W'(X_MIN) : x + X_W'(1);
        if ((y < Y_W'(Y_MIN)) || (y > Y_W'(Y_MAX))) y = Y_W'(Y_MIN);
        else if (carry) y = (y == Y_W'(Y_MAX)) ? Y_W'(Y_MIN) : y + Y_W'(1);
        return {x, y};
    endfunction

    assign reject_state = (sweep_on || tries_last) ? ST_FALLBACK : ST_SAMPLE;
`else
    assign reject_state = tries_last ? ST_FALLBACK : ST_SAMPLE;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (Place_Req) state_next = ST_SAMPLE;
            ST_SAMPLE:     state_next = samp_ok ? ST_CHECK_BLK : reject_state;
            ST_CHECK_BLK: begin
                if (blk_hit)               state_next = reject_state;
                else if (Body_Len == '0)   state_next = ST_COMMIT;
                else                       state_next = ST_CHECK_BODY;
            end
            ST_CHECK_BODY: begin
                if (body_hit)       state_next = reject_state;
                else if (body_last) state_next = ST_COMMIT;
            end
            ST_COMMIT:     state_next = ST_IDLE;
`ifdef TARGET_SCAN_FALLBACK_EN
            ST_FALLBACK:   state_next = sweep_end ? ST_IDLE : ST_CHECK_BLK;
`else
            ST_FALLBACK:   state_next = ST_IDLE;
`endif
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cand_d     = cand;
        tries_d    = tries;
        scan_vld_d = scan_vld;
        rd_addr_d  = Body_Rd_Addr;
        target_d   = Target_Address;
        done_d     = 1'b0;
        fail_d     = 1'b0;
`ifdef TARGET_SCAN_FALLBACK_EN
        sweep_on_d  = sweep_on;
        sweep_cnt_d = sweep_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (Place_Req) tries_d = '0;
`ifdef TARGET_SCAN_FALLBACK_EN
                sweep_on_d  = 1'b0;
                sweep_cnt_d = '0;
`endif
            end
            ST_SAMPLE:    cand_d = samp;
            ST_CHECK_BLK: begin
                rd_addr_d  = '0;
                scan_vld_d = 1'b0;
            end
            ST_CHECK_BODY: begin
                rd_addr_d  = Body_Rd_Addr + LEN_W'(1);
                scan_vld_d = 1'b1;
            end
            ST_COMMIT: begin
                target_d = cand;
                done_d   = 1'b1;
            end
            ST_FALLBACK: begin
`ifdef TARGET_SCAN_FALLBACK_EN
                if (sweep_end) begin
                    target_d = DEF_ADDR;
                    done_d   = 1'b1;
                    fail_d   = 1'b1;
                end else begin
                    cand_d      = step_cell(cand);
                    sweep_on_d  = 1'b1;
                    sweep_cnt_d = sweep_cnt + SWEEP_W'(1);
                end
`else
                target_d = DEF_ADDR;
                done_d   = 1'b1;
                fail_d   = 1'b1;
`endif
            end
            default: ;
        endcase
        if (reject_c) tries_d = tries + TRY_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cand           <= '0;
            tries          <= '0;
            scan_vld       <= 1'b0;
            Body_Rd_Addr   <= '0;
            Target_Address <= DEF_ADDR;
            Place_Done     <= 1'b0;
            Place_Fail     <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            cand           <= cand_d;
            tries          <= tries_d;
            scan_vld       <= scan_vld_d;
            Body_Rd_Addr   <= rd_addr_d;
            Target_Address <= target_d;
            Place_Done     <= done_d;
            Place_Fail     <= fail_d;
            Busy           <= (state_next != ST_IDLE);
        end
    end

`ifdef TARGET_SCAN_FALLBACK_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sweep_on  <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            sweep_on  <= sweep_on_d;
            sweep_cnt <= sweep_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_target_placement_ctrl.sv
// Directed bench for target_placement_ctrl with a 1-cycle-latency body RAM model.
module tb_target_placement_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        place_req;
    logic [7:0]  rand_x;
    logic [6:0]  rand_y;
    logic [59:0] blk_addr;
    logic [5:0]  body_len;
    logic [5:0]  body_rd_addr;
    logic [14:0] body_rd_data;
    logic [14:0] target_addr;
    logic        place_done;
    logic        place_fail;
    logic        busy;

    logic [14:0] body_mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) body_rd_data <= body_mem[body_rd_addr];

    target_placement_ctrl #(.NUM_BLK(4), .MAX_LEN(64), .LEN_W(6), .MAX_TRIES(16)) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .Place_Req      (place_req),
        .Rand_X         (rand_x),
        .Rand_Y         (rand_y),
        .Block_Address  (blk_addr),
        .Body_Len       (body_len),
        .Body_Rd_Addr   (body_rd_addr),
        .Body_Rd_Data   (body_rd_data),
        .Target_Address (target_addr),
        .Place_Done     (place_done),
        .Place_Fail     (place_fail),
        .Busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] xy(input int x, input int y);
        return {8'(x), 7'(y)};
    endfunction

    task automatic set_blk(input logic [14:0] a0, input logic [14:0] a1,
                           input logic [14:0] a2, input logic [14:0] a3);
        blk_addr = {a3, a2, a1, a0};
    endtask

    // Issues one request; the first sample is presented at the request, the second from the next cycle on.
    task automatic run_place(input logic [14:0] first, input logic [14:0] second,
                             input int max_cyc, input bit extra_reqs,
                             output int lat, output logic [14:0] addr, output logic fail,
                             output int ndone, output int dbl);
        logic prev;
        lat = 0; addr = '0; fail = 1'b0; ndone = 0; dbl = 0; prev = 1'b0;
        @(negedge clk);
        {rand_x, rand_y} = first;
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk); #1;
            if (n == 1) {rand_x, rand_y} = second;
            place_req = extra_reqs && (n == 3 || n == 5);
            if (place_done) begin
                if (lat == 0) begin
                    lat  = n;
                    addr = target_addr;
                    fail = place_fail;
                end
                ndone++;
                if (prev) dbl++;
            end
            prev = place_done;
        end
        place_req = 1'b0;
    endtask

    logic [14:0] first_tbl  [5];
    logic [14:0] second_tbl [5];

    initial begin
        int lat, ndone, dbl, cnt;
        logic [14:0] addr;
        logic fail;

        rst_n = 1'b0; place_req = 1'b0; rand_x = '0; rand_y = '0; body_len = '0;
        for (int i = 0; i < 64; i++) body_mem[i] = xy(100 + i / 2, 100);
        set_blk(xy(5, 5), xy(6, 6), xy(70, 70), xy(7, 7));
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_target", target_addr, 15'h1B8D);
        check("rst_busy", busy, 0);
        check("rst_done", place_done, 0);
        check("rst_fail", place_fail, 0);
        check("rst_rdaddr", body_rd_addr, 0);

        // Clean placement with a three-segment body scan.
        body_len = 6'd3;
        body_mem[0] = xy(10, 10); body_mem[1] = xy(11, 10); body_mem[2] = xy(12, 10);
        run_place(xy(40, 20), xy(40, 20), 20, 1'b0, lat, addr, fail, ndone, dbl);
        check("clean_lat", lat, 7);
        check("clean_addr", addr, xy(40, 20));
        check("clean_fail", fail, 0);
        check("clean_ndone", ndone, 1);
        check("clean_hold", target_addr, xy(40, 20));

        // Obstacle 2 rejects the first sample.
        set_blk(xy(5, 5), xy(6, 6), xy(40, 20), xy(7, 7));
        body_len = 6'd0;
        run_place(xy(40, 20), xy(41, 20), 20, 1'b0, lat, addr, fail, ndone, dbl);
        check("blk_lat", lat, 5);
        check("blk_addr", addr, xy(41, 20));
        check("blk_fail", fail, 0);

        // Wall and out-of-range samples rejected in SAMPLE.
        first_tbl[0] = xy(0, 50);   second_tbl[0] = xy(158, 118);
        first_tbl[1] = xy(159, 50); second_tbl[1] = xy(1, 1);
        first_tbl[2] = xy(50, 0);   second_tbl[2] = xy(1, 118);
        first_tbl[3] = xy(50, 119); second_tbl[3] = xy(158, 1);
        first_tbl[4] = xy(200, 50); second_tbl[4] = xy(80, 60);
        for (int i = 0; i < 5; i++) begin
            run_place(first_tbl[i], second_tbl[i], 12, 1'b0, lat, addr, fail, ndone, dbl);
            check($sformatf("wall%0d_lat", i), lat, 4);
            check($sformatf("wall%0d_addr", i), addr, second_tbl[i]);
        end

        // Every sample off-field: exhaust the tries.
        run_place(xy(200, 50), xy(200, 50), 40, 1'b0, lat, addr, fail, ndone, dbl);
`ifdef TARGET_SCAN_FALLBACK_EN
        check("fb_lat", lat, 19);
        check("fb_addr", addr, xy(1, 51));
        check("fb_fail", fail, 0);
`else
        check("fb_lat", lat, 17);
        check("fb_addr", addr, 15'h1B8D);
        check("fb_fail", fail, 1);
`endif
        check("fb_ndone", ndone, 1);
        check("fb_dbl", dbl, 0);

        // Body hit on the last segment, with stray requests while busy.
        body_len = 6'd3;
        run_place(xy(12, 10), xy(41, 20), 30, 1'b1, lat, addr, fail, ndone, dbl);
        check("body2_lat", lat, 13);
        check("body2_addr", addr, xy(41, 20));
        check("body2_ndone", ndone, 1);
        check("body2_dbl", dbl, 0);

        // Body hit on a middle segment aborts the scan early.
        run_place(xy(11, 10), xy(42, 21), 30, 1'b0, lat, addr, fail, ndone, dbl);
        check("body1_lat", lat, 12);
        check("body1_addr", addr, xy(42, 21));
        check("body1_fail", fail, 0);

        // Reset in the middle of the body scan.
        @(negedge clk);
        {rand_x, rand_y} = xy(50, 50);
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_target", target_addr, 15'h1B8D);
        check("mrst_done", place_done, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (place_done || busy) cnt++;
        end
        check("mrst_quiet", cnt, 0);
        check("mrst_hold", target_addr, 15'h1B8D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/target_placement_ctrl.md
Name: target_placement_ctrl

Overview:
- Sequences placement of a new apple target after the snake eats the current one.
- Each attempt samples the free-running 8-bit/7-bit LFSR coordinates and checks them against the play-field bounds, the obstacle list and every snake body segment. Rejected samples are retried.
- The committed address is driven to the renderer and to the collision logic.
- Sits between the snake motion controller (which issues requests) and the body-segment RAM (which this block reads).

Parameters:
- NUM_BLK, 4, number of obstacles on the flattened Block_Address bus.
- MAX_LEN, 64, maximum snake length; sets the body RAM depth.
- LEN_W, 6, width of the body index, equal to clog2(MAX_LEN).
- MAX_TRIES, 16, number of rejected samples allowed before fallback.
- DEF_ADDR, {8'd55,7'd13} = 15'h1B8D, target address after reset and after fallback.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- Place_Req  in  1  one-cycle pulse requesting a new target. Sampled only in IDLE.
- Rand_X  in  8  LFSR8 output, free-running.
- Rand_Y  in  7  LFSR7 output, free-running.
- Block_Address  in  NUM_BLK*15  obstacle addresses; obstacle k is at bits [15k+14:15k], each as {x[7:0],y[6:0]}.
- Body_Len  in  LEN_W  number of valid body segments (0..MAX_LEN-1). Stable while Busy.
- Body_Rd_Addr  out  LEN_W  body RAM read index.
- Body_Rd_Data  in  15  body segment address; synchronous RAM, 1-cycle read latency.
- Target_Address  out  15  committed target address.
- Place_Done  out  1  one-cycle pulse when Target_Address has been updated.
- Place_Fail  out  1  high together with Place_Done when the fallback address was used.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE, Target_Address=DEF_ADDR.
  - Place_Done=0, Place_Fail=0, Busy=0.
  - Body_Rd_Addr=0, try counter=0.
- IDLE:
  - On Place_Req=1, clear the try counter and go to SAMPLE.
  - Place_Req while Busy is ignored; there is no queueing. The requester waits for Place_Done.
- SAMPLE (1 cycle):
  - Latch cand={Rand_X,Rand_Y}.
  - The candidate is in-field when 1<=x<=158 and 1<=y<=118. If in-field, go to CHECK_BLK; otherwise reject.
- CHECK_BLK (1 cycle):
  - Compare cand with all NUM_BLK obstacles in parallel, using full 15-bit equality.
  - Any match rejects.
  - If there is no match and Body_Len=0, go to COMMIT. Otherwise set Body_Rd_Addr=0 and go to CHECK_BODY.
- CHECK_BODY:
  - Pipelined scan: each cycle increments Body_Rd_Addr and compares the returned Body_Rd_Data with cand.
  - The scan takes Body_Len+1 cycles.
  - Any match rejects immediately and aborts the scan.
  - Go to COMMIT after the last segment compares clean.
- Reject:
  - Increment the try counter.
  - If the counter has reached MAX_TRIES, go to FALLBACK; otherwise return to SAMPLE. The LFSRs have advanced by then, so the new sample differs.
- COMMIT (1 cycle):
  - Target_Address<=cand, Place_Done=1, Place_Fail=0, then return to IDLE.
- FALLBACK (1 cycle):
  - Target_Address<=DEF_ADDR, Place_Done=1, Place_Fail=1, then return to IDLE.
- Latency: best case from Place_Req to Place_Done is 3+(Body_Len>0 ? Body_Len+1 : 0) cycles.
- Boundaries:
  - x=0, x=159, y=0 and y=119 lie on the wall and are rejected.
  - Rand_X>=160 is rejected; there is no wrap or offset correction.
  - A reset mid-scan aborts immediately. Target_Address returns to DEF_ADDR and no Place_Done is issued.
- Output timing: Target_Address changes only in COMMIT or FALLBACK and holds otherwise. Place_Done is never high two cycles in a row.

Optional Feature:
- Macro: TARGET_SCAN_FALLBACK_EN.
- Defined: FALLBACK does not commit DEF_ADDR. It instead steps deterministically from the last cand, incrementing x and wrapping from 158 to 1, and carrying into y with y wrapping from 118 to 1.
  - Each step re-runs CHECK_BLK and CHECK_BODY.
  - The first free cell is committed with Place_Fail=0.
  - If a full field sweep (158*118 cells) finds nothing, DEF_ADDR is committed with Place_Fail=1.
- Undefined: behaviour is exactly as described under Behaviour.

Decomposition:
- Shared package snake_pkg holds:
  - coordinate widths X_W=8 and Y_W=7;
  - field limits X_MIN=1, X_MAX=158, Y_MIN=1, Y_MAX=118;
  - the addr_t 15-bit typedef;
  - DEF_ADDR;
  - the state enum.
- One sub-module, addr_hit_cmp: a combinational parallel compare of one candidate against NUM_BLK addresses, giving a one-bit hit. It can also be reused by the collision logic.

Test Plan:
- Reset release, no request → Target_Address=15'h1B8D, Busy=0, Place_Done=0.
- Rand=(40,20), no obstacle hit, Body_Len=3, body={(10,10),(11,10),(12,10)}, Place_Req → Place_Done 7 cycles later, Target_Address={8'd40,7'd20}, Place_Fail=0.
- First sample (40,20) equals obstacle 2, next sample (41,20) is free, Body_Len=0 → commit (41,20) with try count 1.
- Rand_X forced to 200 for every sample, MAX_TRIES=16 → after 16 rejections Place_Done=1, Place_Fail=1, Target_Address=15'h1B8D. With the macro defined, the scan commits the first free cell instead.
- Sample (12,10) matches body segment 2 → scan aborts at index 2 and a resample follows. Place_Req pulses during Busy are ignored, giving exactly one Place_Done.
- RESET_N pulled low mid CHECK_BODY → Busy=0 at once, Target_Address=15'h1B8D, no Place_Done pulse.
